// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned restoring divider for div/divu; LO <= quotient, HI <= remainder.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips iteration and completes the cycle after issue.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic        valid,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state;
  logic [5:0]  count;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        qsign;
  logic        rsign;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shifted;
  logic        qbit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] lo_fix;
  logic [31:0] hi_fix;

  always_comb begin
    a_abs    = (signed_div & a[31]) ? -a : a;
    b_abs    = (signed_div & b[31]) ? -b : b;
    shifted  = {rem, dvd[31]};
    qbit     = (shifted >= {1'b0, dvs});
    // Remainder stays below the divisor, so the 32-bit wrap of the difference is exact.
    rem_next = qbit ? (shifted[31:0] - dvs) : shifted[31:0];
    quo_next = {dvd[30:0], qbit};
    // Zero divisor: all-ones quotient regardless of sign; remainder naturally restores to a.
    lo_fix   = (dvs == 32'd0) ? 32'hFFFF_FFFF : (qsign ? -quo_next : quo_next);
    hi_fix   = rsign ? -rem_next : rem_next;
    stall    = (start & (state == StIdle) & ~cancel) | busy;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= StIdle;
      count  <= 6'd0;
      rem    <= 32'd0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      lo_out <= 32'd0;
      hi_out <= 32'd0;
    end else if (cancel) begin
      state <= StIdle;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          valid <= 1'b0;
          if (start) begin
            dvd   <= a_abs;
            dvs   <= b_abs;
            qsign <= signed_div & (a[31] ^ b[31]);
            rsign <= signed_div & a[31];
            count <= 6'd0;
            rem   <= 32'd0;
`ifdef DIV_ZERO_FAST_EN
            if (b == 32'd0) begin
              state  <= StDone;
              valid  <= 1'b1;
              lo_out <= 32'hFFFF_FFFF;
              hi_out <= a;
            end else begin
              state <= StBusy;
              busy  <= 1'b1;
            end
`else
            state <= StBusy;
            busy  <= 1'b1;
`endif
          end
        end
        StBusy: begin
          rem   <= rem_next;
          dvd   <= quo_next;
          count <= count + 6'd1;
          // Last step retires straight into the result registers so valid follows E32.
          if (count == 6'd31) begin
            state  <= StDone;
            busy   <= 1'b0;
            valid  <= 1'b1;
            lo_out <= lo_fix;
            hi_out <= hi_fix;
          end
        end
        StDone: begin
          valid <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
